// File: rtl/gray_arb_pkg.sv
// Shared definitions for the Gray-conversion arbiter: FSM state encoding
// and default geometry.
// Optional feature macro used by this slice: GRAY_DECODE_EN.
package gray_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam int DEF_WIDTH = 5;
    localparam int DEF_N_REQ = 4;

endpackage

// File: rtl/gray_conv_arbiter_b2g_core.sv
// b2g_core: purely combinational binary/Gray converter for the shared
// conversion datapath.
// With GRAY_DECODE_EN defined, a dir input selects decode (1) or encode (0);
// otherwise the core only encodes.
module b2g_core
    import gray_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] operand,
`ifdef GRAY_DECODE_EN
    input  logic             dir,
`endif
    output logic [WIDTH-1:0] result
);

    function automatic logic [WIDTH-1:0] gray_encode(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

`ifdef GRAY_DECODE_EN
    // Bit i of the binary value is the XOR of all Gray bits at or above i,
    // which is the XOR of every right-shifted copy of the Gray word.
    function automatic logic [WIDTH-1:0] gray_decode(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = g;
        for (int unsigned k = 1; k < WIDTH; k++) begin
            b = b ^ (g >> k);
        end
        return b;
    endfunction
`endif

    // Select the conversion direction for the latched operand
    always_comb begin
`ifdef GRAY_DECODE_EN
        result = dir ? gray_decode(operand) : gray_encode(operand);
`else
        result = gray_encode(operand);
`endif
    end

endmodule

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: round-robin arbiter sharing one registered Gray
// conversion datapath among N_REQ requesters, with a valid/ready response
// channel that returns the result and the requester ID.
// Optional feature macro: GRAY_DECODE_EN (adds req_dir, enables decode).
module gray_conv_arbiter
    import gray_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   busy
`ifdef GRAY_DECODE_EN
    ,
    input  logic [N_REQ-1:0]       req_dir
`endif
);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("gray_conv_arbiter: N_REQ must be in 2..8");
    end
    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("gray_conv_arbiter: WIDTH must be in 2..16");
    end

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic [ID_W-1:0]  ptr_q;
    logic [ID_W-1:0]  id_q;
    logic [WIDTH-1:0] op_q;
    logic [WIDTH-1:0] conv_result;

    logic [WIDTH-1:0] req_word [N_REQ];
    logic             grant_any;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  cand;
    logic             accept;
    logic             rsp_fire;

`ifdef GRAY_DECODE_EN
    logic             dir_q;
`endif

    // Split the flat request bus into one operand per requester
    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            req_word[i] = req_data[i*WIDTH +: WIDTH];
        end
    end

    // Round-robin pick: first valid index searching upward from ptr, wrapping
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = ID_W'((32'(ptr_q) + k) % 32'(N_REQ));
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign accept   = (state_q == IDLE) && grant_any;
    assign rsp_fire = (state_q == RESP) && rsp_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_any) state_d = CONV;
            CONV:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: one-hot accept only while idle, busy while a transaction is in flight
    always_comb begin
        req_ready = '0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    req_ready[grant_idx] = 1'b1;
                end
            end
            CONV, RESP: busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Shared conversion core between the operand latch and the response register
    b2g_core #(
        .WIDTH (WIDTH)
    ) u_b2g_core (
        .operand (op_q),
`ifdef GRAY_DECODE_EN
        .dir     (dir_q),
`endif
        .result  (conv_result)
    );

    // Operand/ID latch on accept; later req_valid changes cannot disturb it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= '0;
            id_q <= '0;
`ifdef GRAY_DECODE_EN
            dir_q <= 1'b0;
`endif
        end else if (accept) begin
            op_q <= req_word[grant_idx];
            id_q <= grant_idx;
`ifdef GRAY_DECODE_EN
            dir_q <= req_dir[grant_idx];
`endif
        end
    end

    // Registered response channel, held stable in RESP until the handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else if (state_q == CONV) begin
            rsp_valid <= 1'b1;
            rsp_data  <= conv_result;
            rsp_id    <= id_q;
        end else if (rsp_fire) begin
            rsp_valid <= 1'b0;
        end
    end

    // Round-robin pointer moves past the served requester only on handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (rsp_fire) begin
            ptr_q <= ID_W'((32'(id_q) + 32'd1) % 32'(N_REQ));
        end
    end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Self-checking bench for gray_conv_arbiter: table-driven single transactions
// plus directed sequences for round-robin order, backpressure and reset.
module tb_gray_conv_arbiter;

    localparam int N = 4;
    localparam int W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_data;
    logic [1:0]       rsp_id;
    logic             busy;
    logic [N-1:0]     req_dir;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gray_conv_arbiter #(
        .N_REQ (N),
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
`ifdef GRAY_DECODE_EN
        ,
        .req_dir   (req_dir)
`endif
    );

    typedef struct {
        int         id;
        logic [4:0] data;
        logic       dir;
        logic [4:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One isolated transaction: accept, CONV, response with one-cycle handshake
    task automatic do_txn(input int id, input logic [4:0] data, input logic dir,
                          input logic [4:0] exp);
        @(negedge clk);
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_data[id*W +: W] = data;
        req_dir = '0;
        req_dir[id] = dir;
        rsp_ready = 1'b0;
        #1 chk("txn req_ready", 32'(req_ready), 32'(1) << id);
        @(negedge clk);
        req_valid = '0;
        chk("txn conv rsp_valid", 32'(rsp_valid), 0);
        chk("txn conv busy", 32'(busy), 1);
        chk("txn conv req_ready", 32'(req_ready), 0);
        @(negedge clk);
        chk("txn rsp_valid", 32'(rsp_valid), 1);
        chk("txn rsp_data", 32'(rsp_data), 32'(exp));
        chk("txn rsp_id", 32'(rsp_id), 32'(id));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("txn done rsp_valid", 32'(rsp_valid), 0);
        chk("txn done busy", 32'(busy), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vec_t vecs[6];
        logic [4:0] rr_gray [4];
        int rr_ids [5];
        int n_rsp;

        vecs[0] = '{id: 0, data: 5'b10001, dir: 1'b0, exp: 5'b11001};
        vecs[1] = '{id: 1, data: 5'b00000, dir: 1'b0, exp: 5'b00000};
        vecs[2] = '{id: 2, data: 5'b11111, dir: 1'b0, exp: 5'b10000};
        vecs[3] = '{id: 3, data: 5'b01111, dir: 1'b0, exp: 5'b01000};
        vecs[4] = '{id: 1, data: 5'b00110, dir: 1'b0, exp: 5'b00101};
        vecs[5] = '{id: 3, data: 5'b10100, dir: 1'b0, exp: 5'b11110};

        rr_gray[0] = 5'b00010;  // 3
        rr_gray[1] = 5'b00101;  // 6
        rr_gray[2] = 5'b01101;  // 9
        rr_gray[3] = 5'b01010;  // 12
        rr_ids = '{0, 1, 2, 3, 0};

        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        req_dir = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset rsp_valid", 32'(rsp_valid), 0);
        chk("reset rsp_data", 32'(rsp_data), 0);
        chk("reset rsp_id", 32'(rsp_id), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset req_ready", 32'(req_ready), 0);
        rst = 1'b0;

        // Table of isolated encode transactions
        for (int i = 0; i < 6; i++) begin
            do_txn(vecs[i].id, vecs[i].data, vecs[i].dir, vecs[i].exp);
        end

        // All requesters valid from reset, consumer always ready: order 0,1,2,3,0
        pulse_reset();
        req_data = {5'd12, 5'd9, 5'd6, 5'd3};
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1 chk("rr first req_ready", 32'(req_ready), 32'b0001);
        n_rsp = 0;
        for (int cyc = 0; cyc < 40 && n_rsp < 5; cyc++) begin
            @(negedge clk);
            if (rsp_valid) begin
                chk("rr rsp_id", 32'(rsp_id), 32'(rr_ids[n_rsp]));
                chk("rr rsp_data", 32'(rsp_data), 32'(rr_gray[rr_ids[n_rsp]]));
                n_rsp++;
            end
        end
        chk("rr response count", 32'(n_rsp), 5);
        req_valid = '0;
        rsp_ready = 1'b0;

        // Backpressure: hold RESP 5 cycles, then ptr must move past requester 2
        pulse_reset();
        req_data = '0;
        req_data[2*W +: W] = 5'b10100;
        req_data[1*W +: W] = 5'b00110;
        req_valid = 4'b0100;
        #1 chk("bp req_ready", 32'(req_ready), 32'b0100);
        @(negedge clk);
        @(negedge clk);
        chk("bp rsp_valid", 32'(rsp_valid), 1);
        req_valid = 4'b0110;
        repeat (5) begin
            @(negedge clk);
            chk("bp hold rsp_valid", 32'(rsp_valid), 1);
            chk("bp hold rsp_data", 32'(rsp_data), 32'b11110);
            chk("bp hold rsp_id", 32'(rsp_id), 2);
            chk("bp hold req_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp after rsp_valid", 32'(rsp_valid), 0);
        chk("bp after busy", 32'(busy), 0);
        #1 chk("bp wrap req_ready", 32'(req_ready), 32'b0010);

        // Requester 1 accepted; reset during its CONV cycle discards it
        @(negedge clk);
        req_valid = '0;
        chk("rst conv busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("rst async rsp_valid", 32'(rsp_valid), 0);
        chk("rst async rsp_data", 32'(rsp_data), 0);
        chk("rst async rsp_id", 32'(rsp_id), 0);
        chk("rst async busy", 32'(busy), 0);
        @(negedge clk);
        chk("rst next rsp_valid", 32'(rsp_valid), 0);
        chk("rst next busy", 32'(busy), 0);
        chk("rst next req_ready", 32'(req_ready), 0);
        rst = 1'b0;
        req_valid = 4'b1111;
        #1 chk("rst restart req_ready", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        chk("rst restart rsp_valid", 32'(rsp_valid), 1);
        chk("rst restart rsp_id", 32'(rsp_id), 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

`ifdef GRAY_DECODE_EN
        do_txn(2, 5'b11001, 1'b1, 5'b10001);
        do_txn(0, 5'b10000, 1'b1, 5'b11111);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_conv_arbiter.md
# gray_conv_arbiter

- Shares one registered binary-to-Gray conversion datapath among `N_REQ` requesters.
- Arbitrates requests round-robin, sequences each accepted request through the converter, and returns the result with the requester ID over a valid/ready response channel.
- Sits between producers needing Gray-coded values (pointer logic, encoder-driven counters) and the single conversion resource.

## Interface

Parameters:
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `WIDTH`, default 5: data width in bits; legal range 2..16.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester ID.

Ports:
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  `N_REQ`  per-requester request strobe.
- `req_data`  in  `N_REQ*WIDTH`  per-requester binary operand; requester i occupies `[i*WIDTH +: WIDTH]`.
- `req_ready`  out  `N_REQ`  one-hot accept; a request is accepted in the cycle where `req_valid[i] & req_ready[i]`.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_data`  out  `WIDTH`  converted value.
- `rsp_id`  out  `ID_W`  index of the requester served.
- `busy`  out  1  high in CONV and RESP.

## Operation

- FSM states: IDLE, CONV, RESP.
- IDLE:
  - If any `req_valid` is high, grant the first valid index searching upward from `ptr` with wrap-around.
  - `req_ready[g]` is driven combinationally high for the grant only. All other `req_ready` bits stay 0.
  - Latch `req_data[g]` and `g`, then go to CONV.
  - If no request is valid, stay in IDLE.
- CONV:
  - Register the conversion result `b ^ (b >> 1)` into `rsp_data`.
  - Drive `rsp_id` to `g` and set `rsp_valid`, then go to RESP.
- RESP:
  - Hold `rsp_valid`, `rsp_data` and `rsp_id` stable until `rsp_ready` is high.
  - On the handshake: clear `rsp_valid`, set `ptr` to `(g+1) mod N_REQ`, and return to IDLE.
- `req_ready` is all-zero outside IDLE. Requests held during CONV/RESP wait and are not lost.
- `ptr` advances only on response handshake. It wraps from `N_REQ-1` to 0.
- `req_valid` changes after acceptance have no effect on the transaction in flight.
- Reset values: state IDLE, `ptr` 0, `req_ready` 0, `rsp_valid` 0, `rsp_data` 0, `rsp_id` 0, `busy` 0.
- Reset asserted mid-transaction: the transaction is discarded and no response is produced.

## Timing

- Accept in cycle t (IDLE) → CONV in t+1 → `rsp_valid` high from t+2.
- The minimum response duration is 1 cycle, when `rsp_ready` is already high.
- Best-case throughput: one transaction per 3 cycles. The next accept can occur in the cycle after the response handshake.
- `rsp_*` outputs are registered. `req_ready` is combinational from `req_valid` and `ptr` in IDLE only.
- Under continuous requests from all N, each requester is served exactly once per N transactions.

## Configuration

- Macro: `GRAY_DECODE_EN`.
- Defined:
  - Adds input port `req_dir` (`N_REQ` bits). `req_dir[g]` is latched with the data at accept.
  - dir=0 encodes binary→Gray.
  - dir=1 decodes Gray→binary: `b[W-1]=g[W-1]`, `b[i]=b[i+1]^g[i]`.
- Undefined: the `req_dir` port is absent and every transaction is an encode.

## Structure

- Shared package/include `gray_arb_pkg`:
  - FSM state localparams: IDLE=2'd0, CONV=2'd1, RESP=2'd2.
  - The default `WIDTH` and `N_REQ` constants.
- Sub-module `b2g_core`: purely combinational, parameterised by `WIDTH`.
  - Contains the encode function, plus the decode function when `GRAY_DECODE_EN` is defined.
  - Instantiated once, between the operand latch and the `rsp_data` register.
- The round-robin pick stays inline in the top.

## Test plan

- Single request: requester 0 sends 5'b10001 → `rsp_data` 5'b11001, `rsp_id` 0, `rsp_valid` at accept+2.
- Edge values: 5'b00000 → 00000; 5'b11111 → 10000; 5'b01111 → 01000.
- All four requesters held valid from reset, `rsp_ready`=1 → service order 0,1,2,3,0 with no requester skipped.
- Backpressure: `rsp_ready` low for 5 cycles in RESP → `rsp_*` stable, `req_ready` all 0, no new accept until the handshake.
- Reset asserted during CONV → next cycle all outputs at reset values, and the next service starts from requester 0.
- With `GRAY_DECODE_EN` defined: dir=1, data 5'b11001 → `rsp_data` 5'b10001.
